spike_rate_decoder: RTL and testbench
=====================================

Name: spike_rate_decoder

Overview:
- Receive-side counterpart to the LIF neuron array: consumes N parallel spike lines and decodes them into per-channel spike counts over a programmable time window.
- At each window end, snapshots all counts and streams them out one channel per beat over a valid/ready interface.
- Sits downstream of the neuron layer's spike bus and feeds the readout/host path.

Parameters:
- N_CH, 8, number of spike input channels.
- CNT_W, 8, width of each per-channel spike count; saturating.
- WIN_W, 8, width of window length and window counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- ena  input  1  counting enable; low freezes window and live counts.
- spike_in  input  N_CH  spike lines, 1 = spike this cycle.
- window_len  input  WIN_W  window length in cycles; 0 means 2^WIN_W.
- out_valid  output  1  readout beat valid.
- out_ready  input  1  downstream accepts the beat.
- out_chan  output  $clog2(N_CH)  channel index of the current beat.
- out_count  output  CNT_W  snapshot count for out_chan.
- window_done  output  1  one-cycle pulse when a window closes.
- overrun  output  1  sticky; set when a window closes while readout is busy.

Behaviour:
- Reset (async, rst_n=0) clears everything:
  - all outputs are 0;
  - window counter, live counts and snapshot registers are 0;
  - FSM state is IDLE.
- Counting (ena=1):
  - win_cnt increments each cycle.
  - live_cnt[i] increments when spike_in[i]=1 and saturates at 2^CNT_W-1; it never wraps.
- Window end:
  - Window end is the cycle T where ena=1 and win_cnt >= eff_len-1, with eff_len = (window_len==0) ? 2^WIN_W : window_len.
  - Using >= means a mid-window shrink of window_len closes the window immediately and never wraps.
- At window end cycle T:
  - Spikes sampled at T are included in the closing window.
  - At T+1: win_cnt=0 and live counts=0; counting resumes at T+1.
  - window_done=1 for exactly cycle T+1.
- ena=0: win_cnt and live counts hold; spikes are ignored; readout continues unaffected.
- FSM states: IDLE, SEND.
  - IDLE: on window end at T, the snapshot loads at T+1; state becomes SEND, out_valid=1 and out_chan=0 at T+1.
  - SEND: out_count = snap[out_chan]; out_valid, out_chan and out_count stay stable until out_ready=1.
  - SEND, on accept (out_valid & out_ready): if out_chan < N_CH-1, increment out_chan the next cycle; else return to IDLE with out_valid=0 the next cycle.
  - out_ready held high drains all N_CH beats in N_CH consecutive cycles.
- Window end while in SEND (including the same cycle as the final accept):
  - the snapshot is NOT overwritten and the new window's counts are discarded;
  - overrun is set and stays set until reset;
  - window_done still pulses; counting restarts normally.
- out_ready asserted while out_valid=0 is ignored.
- Reset asserted mid-readout aborts the burst immediately: out_valid drops asynchronously.

Optional Feature:
- Macro: SPIKE_RATE_DECODER_ARGMAX_EN
- Defined: adds two outputs.
  - win_idx ($clog2(N_CH)): index of the maximum snapshot count; the lowest index wins ties.
  - win_valid (1): pulses at T+2 for each snapshot actually loaded.
  - Both are registered from the snapshot; an all-zero snapshot gives win_idx=0.
  - No win_valid pulse for a window dropped by overrun.
  - Both reset to 0.
- Undefined: neither port exists and no comparator logic is synthesised.

Decomposition:
- Package spike_rate_decoder_pkg holds:
  - state enum (IDLE, SEND);
  - CNT_W/WIN_W default constants;
  - saturating-max localparam helper.
- Sub-module spike_sat_counter (one per channel): CNT_W saturating counter with inc, clr and ena inputs, instantiated N_CH times via generate.
- FSM, window counter and snapshot logic stay in the top module.

Test Plan:
- Basic rate, no backpressure: window_len=10, out_ready=1, spike_in[3] high every cycle, spike_in[5] high every other cycle → 8 beats: count 10 on ch3, 5 on ch5, 0 elsewhere; window_done pulses every 10 cycles.
- Saturation: CNT_W=4, window_len=20, spike_in=8'hFF constant → every out_count=15; no wrap.
- Backpressure: out_ready toggled 1/0 pseudo-randomly → out_chan/out_count stable while stalled; exactly 8 accepted beats in order 0..7 per window.
- Overrun: window_len=4, out_ready=0 for 12 cycles → overrun=1; first snapshot delivered intact after out_ready=1; later windows count fresh.
- Freeze and reset: ena=0 for 5 cycles mid-window with spikes on ch0 → the window lasts 5 extra cycles and the frozen spikes are not counted; rst_n=0 during SEND → out_valid=0 immediately and overrun=0.
- Argmax (macro defined): snapshot counts {3,7,7,1,0,0,0,0} → win_idx=1 with win_valid at T+2; all zero → win_idx=0.

Source files
------------

// File: rtl/spike_rate_decoder_pkg.sv
// Shared types and constants for the spike rate decoder.
// Latency: n/a (types and constant helpers only).
// Backpressure: n/a.
package spike_rate_decoder_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam int N_CH_DEF  = 8;
    localparam int CNT_W_DEF = 8;
    localparam int WIN_W_DEF = 8;

    // Largest value an unsigned counter of the given width can hold.
    function automatic int sat_max(input int width);
        return (1 << width) - 1;
    endfunction

endpackage

// File: rtl/spike_sat_counter.sv
// Per-channel saturating spike counter; cnt_nxt includes this cycle's spike.
// Latency: cnt_nxt is combinational, the stored count updates one cycle later.
// Backpressure: none; ena low holds the count and ignores inc.
module spike_sat_counter
    import spike_rate_decoder_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt_nxt
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(sat_max(CNT_W));

    logic [CNT_W-1:0] cnt;

    always_comb begin
        cnt_nxt = cnt;
        if (ena && inc && (cnt != CNT_MAX)) begin
            cnt_nxt = cnt + CNT_W'(1);
        end
    end

    // Clear wins over increment: the closing cycle's spike is consumed via cnt_nxt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/spike_rate_decoder.sv
// Windowed per-channel spike counting with snapshot readout; SPIKE_RATE_DECODER_ARGMAX_EN adds win_idx/win_valid.
// Latency: snapshot visible and out_valid high the cycle after the window closes; argmax one cycle later.
// Backpressure: out_ready stalls the readout; a window closing mid-readout is dropped and flags overrun.
module spike_rate_decoder
    import spike_rate_decoder_pkg::*;
#(
    parameter int N_CH  = N_CH_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int WIN_W = WIN_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ena,
    input  logic [N_CH-1:0]         spike_in,
    input  logic [WIN_W-1:0]        window_len,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [$clog2(N_CH)-1:0] out_chan,
    output logic [CNT_W-1:0]        out_count,
    output logic                    window_done,
    output logic                    overrun
`ifdef SPIKE_RATE_DECODER_ARGMAX_EN
    ,
    output logic [$clog2(N_CH)-1:0] win_idx,
    output logic                    win_valid
`endif
);

    localparam int CH_W = $clog2(N_CH);

    logic [WIN_W-1:0] win_cnt;
    logic [WIN_W-1:0] win_last;
    logic             win_end;

    logic [CNT_W-1:0] live_nxt [N_CH];
    logic [CNT_W-1:0] snap     [N_CH];

    state_t           state, state_nxt;
    logic [CH_W-1:0]  chan, chan_nxt;
    logic             snap_load;
    logic             overrun_set;

    // Length 0 encodes the full 2^WIN_W window; >= lets a shrunk length close at once.
    assign win_last = (window_len == '0) ? '1 : (window_len - WIN_W'(1));
    assign win_end  = ena && (win_cnt >= win_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt     <= '0;
            window_done <= 1'b0;
        end else begin
            window_done <= win_end;
            if (win_end) begin
                win_cnt <= '0;
            end else if (ena) begin
                win_cnt <= win_cnt + WIN_W'(1);
            end
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        spike_sat_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk     (clk),
            .rst_n   (rst_n),
            .ena     (ena),
            .inc     (spike_in[g]),
            .clr     (win_end),
            .cnt_nxt (live_nxt[g])
        );
    end

    always_comb begin
        state_nxt   = state;
        chan_nxt    = chan;
        snap_load   = 1'b0;
        overrun_set = 1'b0;
        case (state)
            IDLE: begin
                if (win_end) begin
                    snap_load = 1'b1;
                    state_nxt = SEND;
                    chan_nxt  = '0;
                end
            end
            SEND: begin
                overrun_set = win_end;
                if (out_ready) begin
                    if (chan == CH_W'(N_CH - 1)) begin
                        state_nxt = IDLE;
                        chan_nxt  = '0;
                    end else begin
                        chan_nxt = chan + CH_W'(1);
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                chan_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            chan    <= '0;
            overrun <= 1'b0;
        end else begin
            state <= state_nxt;
            chan  <= chan_nxt;
            if (overrun_set) begin
                overrun <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) begin
                snap[i] <= '0;
            end
        end else if (snap_load) begin
            for (int i = 0; i < N_CH; i++) begin
                snap[i] <= live_nxt[i];
            end
        end
    end

    assign out_valid = (state == SEND);
    assign out_chan  = chan;
    assign out_count = out_valid ? snap[chan] : '0;

`ifdef SPIKE_RATE_DECODER_ARGMAX_EN
    logic             snap_loaded;
    logic [CH_W-1:0]  max_idx;
    logic [CNT_W-1:0] max_val;

    // Strict > keeps the lowest index on ties and yields 0 for an all-zero snapshot.
    always_comb begin
        max_idx = '0;
        max_val = snap[0];
        for (int i = 1; i < N_CH; i++) begin
            if (snap[i] > max_val) begin
                max_val = snap[i];
                max_idx = CH_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_loaded <= 1'b0;
            win_valid   <= 1'b0;
            win_idx     <= '0;
        end else begin
            snap_loaded <= snap_load;
            win_valid   <= snap_loaded;
            if (snap_loaded) begin
                win_idx <= max_idx;
            end
        end
    end
`endif

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Scoreboard bench for spike_rate_decoder: directed windows, expected beats queued, monitor compares.
module tb_spike_rate_decoder;

    localparam int N_CH  = 8;
    localparam int CNT_W = 8;
    localparam int WIN_W = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              ena = 1'b0;
    logic              out_ready = 1'b0;
    logic [N_CH-1:0]   spike_in = '0;
    logic [WIN_W-1:0]  window_len = 8'd10;
    logic              out_valid;
    logic [2:0]        out_chan;
    logic [CNT_W-1:0]  out_count;
    logic              window_done;
    logic              overrun;
`ifdef SPIKE_RATE_DECODER_ARGMAX_EN
    logic [2:0]        win_idx;
    logic              win_valid;
`endif

    typedef struct packed {
        logic [2:0]       chan;
        logic [CNT_W-1:0] count;
    } beat_t;

    beat_t exp_q[$];
    int    wexp [N_CH];
    int    n_cmp = 0;
    int    n_err = 0;

    spike_rate_decoder #(
        .N_CH  (N_CH),
        .CNT_W (CNT_W),
        .WIN_W (WIN_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .spike_in    (spike_in),
        .window_len  (window_len),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_chan    (out_chan),
        .out_count   (out_count),
        .window_done (window_done),
        .overrun     (overrun)
`ifdef SPIKE_RATE_DECODER_ARGMAX_EN
        ,
        .win_idx     (win_idx),
        .win_valid   (win_valid)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push_window();
        beat_t b;
        for (int i = 0; i < N_CH; i++) begin
            b.chan  = 3'(i);
            b.count = CNT_W'(wexp[i]);
            exp_q.push_back(b);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares every accepted beat against the queue and checks stall stability.
    initial begin : monitor
        logic             stalled;
        logic [2:0]       s_chan;
        logic [CNT_W-1:0] s_cnt;
        beat_t            e;
        stalled = 1'b0;
        s_chan  = '0;
        s_cnt   = '0;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid) begin
                if (stalled) begin
                    chk("stall_chan", int'(out_chan), int'(s_chan));
                    chk("stall_count", int'(out_count), int'(s_cnt));
                end
                if (out_ready) begin
                    stalled = 1'b0;
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_beat: got chan %0d count %0d, expected no beat",
                                 out_chan, out_count);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat_chan", int'(out_chan), int'(e.chan));
                        chk("beat_count", int'(out_count), int'(e.count));
                    end
                end else begin
                    stalled = 1'b1;
                    s_chan  = out_chan;
                    s_cnt   = out_count;
                end
            end else begin
                stalled = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL timeout: got no finish, expected finish before 100000 ns");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        #3 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_chan", int'(out_chan), 0);
        chk("rst_out_count", int'(out_count), 0);
        chk("rst_window_done", int'(window_done), 0);
        chk("rst_overrun", int'(overrun), 0);
`ifdef SPIKE_RATE_DECODER_ARGMAX_EN
        chk("rst_win_valid", int'(win_valid), 0);
        chk("rst_win_idx", int'(win_idx), 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Basic rate: three 10-cycle windows, ch3 every cycle, ch5 every other.
        window_len = 8'd10;
        out_ready  = 1'b1;
        wexp = '{0, 0, 0, 10, 0, 5, 0, 0};
        repeat (3) push_window();
        for (int k = 0; k <= 30; k++) begin
            step();
            chk("t1_window_done", int'(window_done), int'(k > 0 && k % 10 == 0));
            ena      = (k < 30);
            spike_in = '0;
            if (k < 30) begin
                spike_in[3] = 1'b1;
                spike_in[5] = (k % 2 == 0);
            end
        end
        repeat (12) step();

        // Saturation over the full 256-cycle window (window_len = 0).
        window_len = 8'd0;
        wexp = '{255, 255, 255, 255, 255, 255, 255, 255};
        push_window();
        for (int k = 0; k <= 256; k++) begin
            step();
            chk("t2_window_done", int'(window_done), int'(k == 256));
            ena      = (k < 256);
            spike_in = (k < 256) ? 8'hFF : 8'h00;
        end
        repeat (12) step();

        // Backpressure: random out_ready, then forced high to finish draining.
        window_len = 8'd10;
        wexp = '{10, 0, 0, 0, 0, 0, 0, 3};
        push_window();
        for (int k = 0; k < 80; k++) begin
            step();
            if (k == 10) chk("t3_window_done", int'(window_done), 1);
            ena         = (k < 10);
            spike_in    = '0;
            spike_in[0] = (k < 10);
            spike_in[7] = (k < 3);
            out_ready   = (k < 70) ? 1'($urandom_range(0, 1)) : 1'b1;
        end

        // Overrun: readout stalled across two more window closes.
        window_len = 8'd4;
        out_ready  = 1'b0;
        wexp = '{0, 4, 0, 0, 0, 0, 0, 0};
        push_window();
        for (int k = 0; k <= 12; k++) begin
            step();
            if (k == 4) chk("t4_valid_stalled", int'(out_valid), 1);
            if (k == 7) chk("t4_overrun_before", int'(overrun), 0);
            if (k == 8) chk("t4_overrun_set", int'(overrun), 1);
            ena      = (k < 12);
            spike_in = (k < 4) ? 8'h02 : ((k < 12) ? 8'h04 : 8'h00);
            out_ready = (k == 12);
        end
        repeat (10) step();
        wexp = '{0, 0, 4, 0, 0, 0, 0, 0};
        push_window();
        for (int k = 0; k <= 4; k++) begin
            step();
            ena      = (k < 4);
            spike_in = (k < 4) ? 8'h04 : 8'h00;
        end
        repeat (10) step();
        chk("t4_overrun_sticky", int'(overrun), 1);

        // Freeze: ena low for 5 cycles mid-window, spikes then ignored.
        window_len = 8'd10;
        wexp = '{10, 0, 0, 0, 0, 0, 0, 0};
        push_window();
        for (int k = 0; k <= 15; k++) begin
            step();
            if (k == 10) chk("t5_no_early_close", int'(window_done), 0);
            if (k == 15) chk("t5_late_close", int'(window_done), 1);
            ena         = (k < 5) || (k >= 10 && k < 15);
            spike_in    = '0;
            spike_in[0] = (k < 15);
            spike_in[4] = (k >= 5 && k < 10);
        end
        repeat (10) step();

        // Reset during SEND aborts the burst asynchronously.
        window_len = 8'd4;
        out_ready  = 1'b0;
        for (int k = 0; k <= 4; k++) begin
            step();
            ena      = (k < 4);
            spike_in = (k < 4) ? 8'h01 : 8'h00;
        end
        chk("t6_valid_before_rst", int'(out_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_valid_async_drop", int'(out_valid), 0);
        chk("t6_overrun_cleared", int'(overrun), 0);
        chk("t6_chan_cleared", int'(out_chan), 0);
        chk("t6_count_cleared", int'(out_count), 0);
        repeat (2) step();
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        step();

`ifdef SPIKE_RATE_DECODER_ARGMAX_EN
        // Argmax: tie between ch1 and ch2 resolves to ch1; then an all-zero window.
        window_len = 8'd8;
        wexp = '{3, 7, 7, 1, 0, 0, 0, 0};
        push_window();
        for (int k = 0; k <= 10; k++) begin
            step();
            if (k == 8) chk("am_valid_early", int'(win_valid), 0);
            if (k == 9) begin
                chk("am_valid", int'(win_valid), 1);
                chk("am_idx_tie", int'(win_idx), 1);
            end
            if (k == 10) chk("am_valid_pulse", int'(win_valid), 0);
            ena         = (k < 8);
            spike_in    = '0;
            spike_in[0] = (k < 3);
            spike_in[1] = (k < 7);
            spike_in[2] = (k >= 1 && k < 8);
            spike_in[3] = (k == 0);
        end
        wexp = '{0, 0, 0, 0, 0, 0, 0, 0};
        push_window();
        for (int k = 0; k <= 9; k++) begin
            step();
            if (k == 9) begin
                chk("am_zero_valid", int'(win_valid), 1);
                chk("am_zero_idx", int'(win_idx), 0);
            end
            ena      = (k < 8);
            spike_in = '0;
        end
        repeat (10) step();
`endif

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) step();
        chk("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
